yasac_runner: RTL and testbench
===============================

YASAC_RUNNER -- requirements
Module: yasac_runner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 3, idle cycles between accepted go and cpu_start assertion.
REQ-002 Parameter POST_CYCLES, default 5, cycles between ready detection and port capture.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, watchdog limit in cycles (used only when the watchdog is compiled in).
REQ-004 Parameter EXPECT, default 8'h08, expected port00 value for pass.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 go  in  1  run request, sampled in IDLE only.
REQ-008 cpu_start  out  1  start pulse to the yasac processor.
REQ-009 cpu_ready  in  1  processor ready indicator.
REQ-010 port00, port01  in  8 each  processor output ports to be captured.
REQ-011 res00, res01  out  8 each  captured port values.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 done  out  1  high while in DONE.
REQ-014 pass  out  1  valid while done; res00 == EXPECT and no timeout.
REQ-015 timeout  out  1  valid while done; watchdog expired.
REQ-016 cycles  out  16  cycles from cpu_start assertion to ready detection.

Function
REQ-017 FSM states: IDLE, SETTLE, START, WAIT_LOW, WAIT_HIGH, POST, DONE.
REQ-018 IDLE: go=1 -> SETTLE; SETTLE_CYCLES=0 -> START directly.
REQ-019 SETTLE: stays exactly SETTLE_CYCLES cycles, then -> START.
REQ-020 START: cpu_start=1 for exactly one cycle, then -> WAIT_LOW; cpu_start is 0 in all other states.
REQ-021 WAIT_LOW: cpu_ready=0 -> WAIT_HIGH; ready still high from before start is ignored.
REQ-022 WAIT_HIGH: cpu_ready=1 -> POST; cycles is frozen at this edge.
REQ-023 cycles: cleared in START, +1 per cycle in WAIT_LOW/WAIT_HIGH, saturates at 16'hFFFF.
REQ-024 POST: stays exactly POST_CYCLES cycles; on exit, registers port00/port01 into res00/res01 and -> DONE.
REQ-025 pass is set at the capture edge to (port00 == EXPECT); 8-bit unsigned compare.
REQ-026 DONE: outputs held; go=1 -> SETTLE (new run); pass, timeout and cycles clear on that transition.
REQ-027 go in any state other than IDLE/DONE is ignored.
REQ-028 cpu_ready glitches in POST/DONE are ignored.

Reset
REQ-029 reset=1 at any clock edge, including mid-run, -> IDLE next cycle.
REQ-030 Reset values: cpu_start=0, busy=0, done=0, pass=0, timeout=0, cycles=0, res00=res01=8'h00.
REQ-031 reset has priority over go and cpu_ready in the same cycle.

Configuration
REQ-032 Macro YASAC_RUNNER_TIMEOUT_EN defined: watchdog counts cycles in WAIT_LOW+WAIT_HIGH; count reaching TIMEOUT_CYCLES -> DONE with timeout=1, pass=0, res00/res01 unchanged.
REQ-033 Same cycle as ready detection and expiry: ready wins (-> POST).
REQ-034 Macro undefined: no watchdog logic; timeout tied 0; WAIT states wait indefinitely.

Structure
REQ-035 Shared package yasac_pkg holds the state encoding typedef and the 8-bit port width constant.
REQ-036 One sub-module, yasac_runner_cnt: a loadable down-counter reused for SETTLE and POST timing; all other logic stays in yasac_runner.

Verification
REQ-038 Reset, go at cycle 2, processor model drops ready 1 cycle after start and raises it 10 cycles later with port00=8'h08 -> cpu_start single pulse exactly 3 cycles after go accepted, done 5 cycles after ready, pass=1, cycles=11.
REQ-039 Same run with port00=8'h07 -> done=1, pass=0, res00=8'h07.
REQ-040 Watchdog compiled in, TIMEOUT_CYCLES=20, ready never returns -> done=1, timeout=1, pass=0 after 20 wait cycles.
REQ-041 reset pulsed during WAIT_HIGH -> IDLE next cycle, all outputs at reset values, no cpu_start until a new go.
REQ-042 Ready held high throughout (never drops) with watchdog compiled out -> runner stays in WAIT_LOW, busy=1, done=0 for 2000 cycles.
REQ-043 Second go in DONE -> pass/cycles cleared, new cpu_start after SETTLE_CYCLES, second result captured independently.

Source files
------------

// File: rtl/yasac_pkg.sv
// Shared types and widths for the yasac test runner.
package yasac_pkg;

   localparam int PORT_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_START,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_POST,
      ST_DONE
   } state_e;

endpackage

// File: rtl/yasac_runner_cnt.sv
// Loadable down-counter used for the SETTLE and POST dwell times.
module yasac_runner_cnt
   import yasac_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/yasac_runner.sv
// Sequences one yasac processor run: settle, start pulse, wait for ready, capture ports.
// Define YASAC_RUNNER_TIMEOUT_EN to compile in the wait-state watchdog.
//
// state        | meaning
// ST_IDLE      | after reset, waiting for go
// ST_SETTLE    | dwell SETTLE_CYCLES before starting the processor
// ST_START     | one-cycle cpu_start pulse, cycle counter cleared
// ST_WAIT_LOW  | waiting for cpu_ready to drop (stale ready ignored)
// ST_WAIT_HIGH | waiting for cpu_ready to rise again
// ST_POST      | dwell POST_CYCLES before capturing the ports
// ST_DONE      | results held until the next go
module yasac_runner
   import yasac_pkg::*;
#(
   parameter int unsigned        SETTLE_CYCLES  = 3,
   parameter int unsigned        POST_CYCLES    = 5,
   parameter int unsigned        TIMEOUT_CYCLES = 1000,
   parameter logic [PORT_W-1:0]  EXPECT         = 8'h08
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic              cpu_start,
   input  logic              cpu_ready,
   input  logic [PORT_W-1:0] port00,
   input  logic [PORT_W-1:0] port01,
   output logic [PORT_W-1:0] res00,
   output logic [PORT_W-1:0] res01,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       cycles
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] POST_LD   = CNT_W'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);

   // The watchdog shares the cycles counter, so its limit must fit in 16 bits.
   if (TIMEOUT_CYCLES > 32'h0000_FFFF) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES exceeds the cycles counter range");
   end

   state_e            state_q, state_d;
   logic [PORT_W-1:0] res00_q, res00_d, res01_q, res01_d;
   logic              pass_q, pass_d;
   logic [15:0]       cycles_q, cycles_d;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_load_val;
`ifdef YASAC_RUNNER_TIMEOUT_EN
   logic              timeout_q, timeout_d;
`endif

   yasac_runner_cnt u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      res00_d      = res00_q;
      res01_d      = res01_q;
      pass_d       = pass_q;
      cycles_d     = cycles_q;
      cnt_load     = 1'b0;
      cnt_load_val = SETTLE_LD;
      cnt_dec      = 1'b0;
`ifdef YASAC_RUNNER_TIMEOUT_EN
      timeout_d    = timeout_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               pass_d   = 1'b0;
               cycles_d = '0;
`ifdef YASAC_RUNNER_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               if (SETTLE_CYCLES == 0) begin
                  state_d = ST_START;
               end else begin
                  state_d  = ST_SETTLE;
                  cnt_load = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_zero)
               state_d = ST_START;
            else
               cnt_dec = 1'b1;
         end
         ST_START: begin
            cycles_d = '0;
            state_d  = ST_WAIT_LOW;
         end
         ST_WAIT_LOW, ST_WAIT_HIGH: begin
            if (cycles_q != 16'hFFFF)
               cycles_d = cycles_q + 16'd1;
            // Ready detection takes priority over a watchdog expiring on the same edge.
            if ((state_q == ST_WAIT_HIGH) && cpu_ready) begin
               if (POST_CYCLES == 0) begin
                  res00_d = port00;
                  res01_d = port01;
                  pass_d  = (port00 == EXPECT);
                  state_d = ST_DONE;
               end else begin
                  state_d      = ST_POST;
                  cnt_load     = 1'b1;
                  cnt_load_val = POST_LD;
               end
            end
`ifdef YASAC_RUNNER_TIMEOUT_EN
            else if (({16'd0, cycles_q} + 32'd1) >= TIMEOUT_CYCLES) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = ST_DONE;
            end
`endif
            else if ((state_q == ST_WAIT_LOW) && !cpu_ready) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_POST: begin
            if (cnt_zero) begin
               res00_d = port00;
               res01_d = port01;
               pass_d  = (port00 == EXPECT);
               state_d = ST_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         res00_q  <= '0;
         res01_q  <= '0;
         pass_q   <= 1'b0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         res00_q  <= res00_d;
         res01_q  <= res01_d;
         pass_q   <= pass_d;
         cycles_q <= cycles_d;
      end
   end

`ifdef YASAC_RUNNER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset)
         timeout_q <= 1'b0;
      else
         timeout_q <= timeout_d;
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign cpu_start = (state_q == ST_START);
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign cycles    = cycles_q;
   assign res00     = res00_q;
   assign res01     = res01_q;

endmodule

// File: tb/tb_yasac_runner.sv
// Bench for yasac_runner: timeline reference model, directed runs and random stimulus.
module tb_yasac_runner;

   localparam int unsigned SETTLE = 3;
   localparam int unsigned POST   = 5;
   localparam int unsigned TMO    = 20;
   localparam logic [7:0]  EXP    = 8'h08;
`ifdef YASAC_RUNNER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, go, cpu_ready;
   logic [7:0] port00, port01;
   logic       cpu_start, busy, done, pass, timeout;
   logic [7:0] res00, res01;
   logic [15:0] cycles;

   always #5 clk = ~clk;

   yasac_runner #(
      .SETTLE_CYCLES  (SETTLE),
      .POST_CYCLES    (POST),
      .TIMEOUT_CYCLES (TMO),
      .EXPECT         (EXP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .cpu_start (cpu_start),
      .cpu_ready (cpu_ready),
      .port00    (port00),
      .port01    (port01),
      .res00     (res00),
      .res01     (res01),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout),
      .cycles    (cycles)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a run is a timeline of absolute cycle numbers rather than states.
   int         cyc = 0;
   bit         live = 1'b0;
   bit         m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_timeout = 1'b0;
   bit         m_wait = 1'b0, m_low_seen = 1'b0, m_post = 1'b0;
   int         m_start_at = 0, m_done_at = 0, m_cycles = 0;
   logic [7:0] m_res00 = 8'h00, m_res01 = 8'h00;

   task automatic m_capture();
      m_res00 = port00;
      m_res01 = port01;
      m_pass  = (port00 == EXP);
      m_busy  = 1'b0;
      m_done  = 1'b1;
      m_post  = 1'b0;
   endtask

   task automatic model_step();
      cyc++;
      if (reset) begin
         live = 1'b1;
         m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0;
         m_wait = 1'b0; m_post = 1'b0; m_cycles = 0;
         m_res00 = 8'h00; m_res01 = 8'h00;
         return;
      end
      if (!m_busy) begin
         if (go) begin
            m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0;
            m_cycles = 0; m_wait = 1'b0; m_post = 1'b0;
            m_start_at = cyc + int'(SETTLE);
         end
         return;
      end
      if (m_post) begin
         if (cyc == m_done_at) m_capture();
         return;
      end
      if (m_wait) begin
         if (m_cycles < 65535) m_cycles++;
         if (m_low_seen && cpu_ready) begin
            m_wait = 1'b0;
            if (POST == 0) m_capture();
            else begin
               m_post    = 1'b1;
               m_done_at = cyc + int'(POST);
            end
         end else if (TMO_EN && (m_cycles >= int'(TMO))) begin
            m_wait = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            m_timeout = 1'b1; m_pass = 1'b0;
         end else if (!cpu_ready) begin
            m_low_seen = 1'b1;
         end
         return;
      end
      if (cyc == m_start_at + 1) begin
         m_wait = 1'b1; m_low_seen = 1'b0; m_cycles = 0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (live) begin
         chk("cpu_start", 32'(cpu_start), 32'(m_busy && !m_wait && !m_post && (cyc == m_start_at)));
         chk("busy",      32'(busy),      32'(m_busy));
         chk("done",      32'(done),      32'(m_done));
         chk("pass",      32'(pass),      32'(m_pass));
         chk("timeout",   32'(timeout),   32'(m_timeout));
         chk("cycles",    32'(cycles),    32'(m_cycles));
         chk("res00",     32'(res00),     32'(m_res00));
         chk("res01",     32'(res01),     32'(m_res01));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // go from IDLE/DONE, processor drops ready one cycle after start and raises it hi_delay later.
   task automatic run(input logic [7:0] p0, input logic [7:0] p1, input int hi_delay,
                      output int start_dist, output int done_dist);
      int n;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("go_clears_pass",   32'(pass),   32'd0);
      chk("go_clears_cycles", 32'(cycles), 32'd0);
      n = 0;
      start_dist = -1;
      while ((n < 50) && (start_dist < 0)) begin
         if (cpu_start) start_dist = n;
         else begin
            tick();
            n++;
         end
      end
      chk("start_seen", 32'(start_dist >= 0), 32'd1);
      tick();
      cpu_ready = 1'b0;
      repeat (hi_delay) tick();
      cpu_ready = 1'b1;
      port00 = p0;
      port01 = p1;
      n = 0;
      done_dist = -1;
      while ((n < 50) && (done_dist < 0)) begin
         tick();
         n++;
         if (done) done_dist = n;
      end
      chk("done_seen", 32'(done_dist >= 0), 32'd1);
      port00 = ~p0;
      port01 = ~p1;
      cpu_ready = 1'b0;
      tick();
      cpu_ready = 1'b1;
      tick();
   endtask

   initial begin
      int sd, dd, n, bad;
      reset = 1'b1; go = 1'b0; cpu_ready = 1'b1; port00 = 8'h00; port01 = 8'h00;
      repeat (3) tick();
      chk("rst_cpu_start", 32'(cpu_start), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_pass",      32'(pass),      32'd0);
      chk("rst_timeout",   32'(timeout),   32'd0);
      chk("rst_cycles",    32'(cycles),    32'd0);
      chk("rst_res00",     32'(res00),     32'd0);
      reset = 1'b0;
      tick();

      run(8'h08, 8'h5A, 10, sd, dd);
      chk("a_start_dist", 32'(sd),     32'd3);
      chk("a_done_dist",  32'(dd),     32'd6);
      chk("a_pass",       32'(pass),   32'd1);
      chk("a_cycles",     32'(cycles), 32'd11);
      chk("a_res00",      32'(res00),  32'h08);
      chk("a_res01",      32'(res01),  32'h5A);

      run(8'h07, 8'hA5, 10, sd, dd);
      chk("b_start_dist", 32'(sd),     32'd3);
      chk("b_done",       32'(done),   32'd1);
      chk("b_pass",       32'(pass),   32'd0);
      chk("b_cycles",     32'(cycles), 32'd11);
      chk("b_res00",      32'(res00),  32'h07);

      run(8'h08, 8'h33, 4, sd, dd);
      chk("c_pass",   32'(pass),   32'd1);
      chk("c_cycles", 32'(cycles), 32'd5);
      chk("c_res01",  32'(res01),  32'h33);

      // reset in the middle of WAIT_HIGH
      go = 1'b1; tick(); go = 1'b0;
      n = 0;
      while ((n < 50) && !cpu_start) begin tick(); n++; end
      chk("d_start_seen", 32'(cpu_start), 32'd1);
      tick(); cpu_ready = 1'b0; tick(); tick();
      chk("d_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("d_busy",    32'(busy),    32'd0);
      chk("d_done",    32'(done),    32'd0);
      chk("d_cycles",  32'(cycles),  32'd0);
      chk("d_res00",   32'(res00),   32'd0);
      chk("d_pass",    32'(pass),    32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cpu_ready = ~cpu_ready;
         tick();
         if (cpu_start || busy) bad++;
      end
      chk("d_no_restart", 32'(bad), 32'd0);

`ifdef YASAC_RUNNER_TIMEOUT_EN
      run(8'h08, 8'h11, 3, sd, dd);
      go = 1'b1; tick(); go = 1'b0;
      n = 0;
      while ((n < 50) && !cpu_start) begin tick(); n++; end
      tick(); cpu_ready = 1'b0;
      n = 0;
      while ((n < 100) && !done) begin tick(); n++; end
      chk("e_done",    32'(done),    32'd1);
      chk("e_timeout", 32'(timeout), 32'd1);
      chk("e_pass",    32'(pass),    32'd0);
      chk("e_cycles",  32'(cycles),  32'd20);
      chk("e_res01",   32'(res01),   32'h11);
`else
      cpu_ready = 1'b1;
      go = 1'b1; tick(); go = 1'b0;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (i > 5 && (!busy || done)) bad++;
      end
      chk("e_hang_stable", 32'(bad),  32'd0);
      chk("e_hang_busy",   32'(busy), 32'd1);
      chk("e_hang_done",   32'(done), 32'd0);
      reset = 1'b1; tick(); reset = 1'b0;
`endif

      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         go    = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 4) == 0) cpu_ready = ~cpu_ready;
         port00 = ($urandom_range(0, 1) == 1) ? EXP : 8'($urandom);
         port01 = 8'($urandom);
         tick();
      end
      reset = 1'b0; go = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit: simulation still running at t=%0t", $time);
      $fatal(1, "time limit");
   end

endmodule
